// File: rtl/stopwatch_core_if.sv
// Stopwatch core bundle: 10 ms tick and button levels in, BCD display digits and status out.
//   tick        single-cycle 10 ms enable
//   start_stop  debounced button level
//   clear       debounced button level
//   lap         debounced button level
//   digit3..0   BCD display digits SS.hh (digit3 = tens of seconds)
//   running     FSM is in the running state
//   hold        display shows the frozen lap value
//   overflow    full-scale indication (pulse when wrapping, sticky when saturating)
interface stopwatch_core_if;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       hold;
  logic       overflow;

  modport master (
    output tick, start_stop, clear, lap,
    input  digit3, digit2, digit1, digit0, running, hold, overflow
  );

  modport slave (
    input  tick, start_stop, clear, lap,
    output digit3, digit2, digit1, digit0, running, hold, overflow
  );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping stage: counts 10 ms ticks as four BCD digits (SS.hh), with a
// start/stop/clear control FSM and a lap-hold display latch.
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    stopwatch_core_if.slave: tick and button levels in, digits and status out
module stopwatch_core #(
  parameter int unsigned MAX_TENS_SEC = 5,  // legal 1..9
  parameter bit          WRAP         = 1'b1
) (
  input logic              clk,
  input logic              reset,
  stopwatch_core_if.slave  bus
);

  localparam logic [3:0] MaxTens = 4'(MAX_TENS_SEC);

  typedef enum logic [1:0] {StIdle, StRunning, StPaused} state_e;

  state_e          state_q, state_d;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0][3:0] lap_q, lap_d;
  logic [3:0][3:0] inc;
  logic            hold_q, hold_d;
  logic            ovf_q, ovf_d;
  logic            ss_prev, clr_prev, lap_prev;
  logic            ss_edge, clr_edge, lap_edge;
  logic            c0, c1, c2, full;
  logic            is_run;

  assign ss_edge  = bus.start_stop & ~ss_prev;
  assign clr_edge = bus.clear & ~clr_prev;
  assign lap_edge = bus.lap & ~lap_prev;
  assign is_run   = (state_q == StRunning);

  // BCD carry chain for one tick; full scale is handled separately.
  always_comb begin
    c0   = (cnt_q[0] == 4'd9);
    c1   = c0 && (cnt_q[1] == 4'd9);
    c2   = c1 && (cnt_q[2] == 4'd9);
    full = c2 && (cnt_q[3] == MaxTens);
    inc[0] = c0 ? 4'd0 : cnt_q[0] + 4'd1;
    inc[1] = c0 ? ((cnt_q[1] == 4'd9) ? 4'd0 : cnt_q[1] + 4'd1) : cnt_q[1];
    inc[2] = c1 ? ((cnt_q[2] == 4'd9) ? 4'd0 : cnt_q[2] + 4'd1) : cnt_q[2];
    inc[3] = c2 ? cnt_q[3] + 4'd1 : cnt_q[3];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    ovf_d   = WRAP ? 1'b0 : ovf_q;  // pulse when wrapping, sticky when saturating

    // Tick is qualified by the current state, so a start edge never counts its own tick.
    if (is_run && bus.tick) begin
      if (full) begin
        ovf_d = 1'b1;
        if (WRAP) begin
          cnt_d = '0;
        end else begin
          state_d = StPaused;
        end
      end else begin
        cnt_d = inc;
      end
    end

    if (ss_edge) begin
      unique case (state_q)
        StIdle:    state_d = StRunning;
        StRunning: state_d = StPaused;
        StPaused:  state_d = StRunning;
        default:   state_d = StIdle;
      endcase
    end

    // Lap captures the pre-tick count.
    if (lap_edge) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else if (is_run) begin
        lap_d  = cnt_q;
        hold_d = 1'b1;
      end
    end

    // Clear wins over everything above; in running it is a restart that keeps hold.
    if (clr_edge) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      if (is_run) begin
        state_d = StRunning;
      end else begin
        state_d = StIdle;
        hold_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lap_q    <= '0;
      hold_q   <= 1'b0;
      ovf_q    <= 1'b0;
      // Buttons held through reset release must not produce an edge.
      ss_prev  <= bus.start_stop;
      clr_prev <= bus.clear;
      lap_prev <= bus.lap;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lap_q    <= lap_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      ss_prev  <= bus.start_stop;
      clr_prev <= bus.clear;
      lap_prev <= bus.lap;
    end
  end

  assign bus.digit3   = hold_q ? lap_q[3] : cnt_q[3];
  assign bus.digit2   = hold_q ? lap_q[2] : cnt_q[2];
  assign bus.digit1   = hold_q ? lap_q[1] : cnt_q[1];
  assign bus.digit0   = hold_q ? lap_q[0] : cnt_q[0];
  assign bus.running  = is_run;
  assign bus.hold     = hold_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a wrapping and a saturating instance share stimulus;
// expectations are queued per step and popped against both instances after the clock edge.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stopwatch_core_if bw ();
  stopwatch_core_if bs ();

  stopwatch_core #(.MAX_TENS_SEC(5), .WRAP(1'b1)) dut_w (.clk(clk), .reset(reset), .bus(bw));
  stopwatch_core #(.MAX_TENS_SEC(5), .WRAP(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(bs));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sat;
    logic [15:0] dig;
    logic        run;
    logic        hld;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Drive inputs at negedge, then sample 1 time unit after the next posedge.
  task automatic step(input logic t, input logic s, input logic c, input logic l);
    @(negedge clk);
    bw.tick = t; bw.start_stop = s; bw.clear = c; bw.lap = l;
    bs.tick = t; bs.start_stop = s; bs.clear = c; bs.lap = l;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input bit sat, input logic [15:0] dig,
                      input logic run, input logic hld, input logic ovf);
    exp_t e;
    e.tag = tag; e.sat = sat; e.dig = dig; e.run = run; e.hld = hld; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic push_both(input string tag, input logic [15:0] dig,
                           input logic run, input logic hld, input logic ovf);
    push({tag, "/wrap"}, 1'b0, dig, run, hld, ovf);
    push({tag, "/sat"},  1'b1, dig, run, hld, ovf);
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [15:0] d;
    logic        r, h, o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sat) begin
        d = {bs.digit3, bs.digit2, bs.digit1, bs.digit0};
        r = bs.running; h = bs.hold; o = bs.overflow;
      end else begin
        d = {bw.digit3, bw.digit2, bw.digit1, bw.digit0};
        r = bw.running; h = bw.hold; o = bw.overflow;
      end
      cmp({e.tag, ".digits"},   d, e.dig);
      cmp({e.tag, ".running"},  16'(r), 16'(e.run));
      cmp({e.tag, ".hold"},     16'(h), 16'(e.hld));
      cmp({e.tag, ".overflow"}, 16'(o), 16'(e.ovf));
    end
  endtask

  initial begin
    bw.tick = 1'b0; bw.start_stop = 1'b1; bw.clear = 1'b0; bw.lap = 1'b0;
    bs.tick = 1'b0; bs.start_stop = 1'b1; bs.clear = 1'b0; bs.lap = 1'b0;

    // Reset with start_stop held high.
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    push_both("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    push_both("held_start", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Start, count 123 ticks, stop, further ticks ignored.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(123);
    push_both("count123", 16'h0123, 1'b1, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    push_both("paused", 16'h0123, 1'b0, 1'b0, 1'b0);
    check_pop();

    // Clear from paused, then lap hold.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    push_both("clear_paused", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(50);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push_both("lap_on", 16'h0050, 1'b1, 1'b1, 1'b0);
    check_pop();
    ticks(30);
    push_both("lap_frozen", 16'h0050, 1'b1, 1'b1, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push_both("lap_off", 16'h0080, 1'b1, 1'b0, 1'b0);
    check_pop();

    // Clear while running restarts; stop/start coinciding with tick.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    push_both("clear_running", 16'h0000, 1'b1, 1'b0, 1'b0);
    check_pop();
    ticks(9);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    push_both("stop_tick", 16'h0010, 1'b0, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    push_both("start_tick", 16'h0010, 1'b1, 1'b0, 1'b0);
    check_pop();
    ticks(297);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    push_both("at0307", 16'h0307, 1'b0, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    push_both("clear_start", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    push_both("clear_start_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();

    // Full scale.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5999);
    push_both("full", 16'h5999, 1'b1, 1'b0, 1'b0);
    check_pop();
    ticks(1);
    push("ovf_tick/wrap", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    push("ovf_tick/sat",  1'b1, 16'h5999, 1'b0, 1'b0, 1'b1);
    check_pop();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    push("ovf_next/wrap", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    push("ovf_next/sat",  1'b1, 16'h5999, 1'b0, 1'b0, 1'b1);
    check_pop();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    push("ovf_clear/wrap", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    push("ovf_clear/sat",  1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    ticks(3);
    push("after/wrap", 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    push("after/sat",  1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();

    // Lap in running vs idle, then reset mid-run.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push("lap_mix/wrap", 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0);
    push("lap_mix/sat",  1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    push_both("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
